// File: rtl/ber_prob_loader_if.sv
// Table-word stream between the table source (DMA/BRAM reader) and the loader.
// Master drives s_valid/s_data, slave returns s_ready.
// A beat is transferred on any clock edge where s_valid and s_ready are both high.
interface ber_prob_loader_if #(
   parameter int DATA_W = 64
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/ber_prob_loader.sv
// Loads NUM_ENTRIES probability words into the BER core (core held in reset), then runs it.
// Latency: accepted beat -> write on probability_idx next cycle; ber_en rises 2 cycles after last write.
// Backpressure: s_ready high only in LOAD, drops the cycle after the last beat is accepted.
// Optional RUN timer (run_cycles port) enabled by defining BER_LOADER_RUN_TIMER_EN.
module ber_prob_loader #(
   parameter int NUM_ENTRIES = 64,
   parameter int DATA_W      = 64,
   parameter int IDX_W       = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   ber_prob_loader_if.slave     tbl,
   output logic [IDX_W-1:0]     probability_idx,
   output logic [DATA_W-1:0]    probability_in,
   output logic                 ber_en,
   output logic                 ber_rstn,
   output logic                 busy,
   output logic                 done
`ifdef BER_LOADER_RUN_TIMER_EN
   ,
   input  logic [47:0]          run_cycles
`endif
);

   localparam int                CNT_W    = $clog2(NUM_ENTRIES) + 1;
   localparam logic [IDX_W-1:0]  IDX_IDLE = '1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_ENTRIES - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(NUM_ENTRIES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_RUN
   } state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    count, count_nxt;
   logic                s_ready_r, s_ready_nxt;
   logic [IDX_W-1:0]    idx_nxt;
   logic [DATA_W-1:0]   pin_nxt;
   logic                en_nxt, rstn_nxt, busy_nxt, done_nxt;
   logic                beat;
   logic                expire;

`ifdef BER_LOADER_RUN_TIMER_EN
   // Remaining RUN cycles; zero means unlimited, so it only counts down while nonzero.
   logic [47:0]         tmr, tmr_nxt;
   assign expire = (tmr == 48'd1);
`else
   assign expire = 1'b0;
`endif

   assign tbl.s_ready = s_ready_r;
   assign beat        = tbl.s_valid && s_ready_r;

   // Next-state and next registered-output values.
   always_comb begin
      state_nxt   = state;
      count_nxt   = count;
      s_ready_nxt = s_ready_r;
      idx_nxt     = IDX_IDLE;
      pin_nxt     = probability_in;
      en_nxt      = ber_en;
      rstn_nxt    = ber_rstn;
      done_nxt    = 1'b0;
`ifdef BER_LOADER_RUN_TIMER_EN
      tmr_nxt     = tmr;
`endif
      case (state)
         ST_IDLE: begin
            s_ready_nxt = 1'b0;
            en_nxt      = 1'b0;
            rstn_nxt    = 1'b0;
            // stop in the same cycle as start keeps us idle
            if (start && !stop) begin
               state_nxt   = ST_LOAD;
               count_nxt   = '0;
               s_ready_nxt = 1'b1;
            end
         end
         ST_LOAD: begin
            if (stop) begin
               state_nxt   = ST_IDLE;
               count_nxt   = '0;
               s_ready_nxt = 1'b0;
            end else if (count == CNT_FULL) begin
               state_nxt   = ST_SETTLE;
               s_ready_nxt = 1'b0;
            end else if (beat) begin
               idx_nxt   = IDX_W'(count);
               pin_nxt   = tbl.s_data;
               count_nxt = count + 1'b1;
               // last beat: close the stream so no extra word is accepted
               if (count == CNT_LAST) begin
                  s_ready_nxt = 1'b0;
               end
            end
         end
         ST_SETTLE: begin
            if (stop) begin
               state_nxt = ST_IDLE;
               count_nxt = '0;
            end else begin
               state_nxt = ST_RUN;
               en_nxt    = 1'b1;
               rstn_nxt  = 1'b1;
`ifdef BER_LOADER_RUN_TIMER_EN
               tmr_nxt   = run_cycles;
`endif
            end
         end
         ST_RUN: begin
            if (stop || expire) begin
               state_nxt = ST_IDLE;
               count_nxt = '0;
               en_nxt    = 1'b0;
               rstn_nxt  = 1'b0;
               done_nxt  = 1'b1;
`ifdef BER_LOADER_RUN_TIMER_EN
               tmr_nxt   = '0;
`endif
            end
`ifdef BER_LOADER_RUN_TIMER_EN
            else if (tmr != 48'd0) begin
               tmr_nxt = tmr - 48'd1;
            end
`endif
         end
         default: state_nxt = ST_IDLE;
      endcase
      busy_nxt = (state_nxt != ST_IDLE);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Registered outputs and load counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count           <= '0;
         s_ready_r       <= 1'b0;
         probability_idx <= IDX_IDLE;
         probability_in  <= '0;
         ber_en          <= 1'b0;
         ber_rstn        <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         count           <= count_nxt;
         s_ready_r       <= s_ready_nxt;
         probability_idx <= idx_nxt;
         probability_in  <= pin_nxt;
         ber_en          <= en_nxt;
         ber_rstn        <= rstn_nxt;
         busy            <= busy_nxt;
         done            <= done_nxt;
      end
   end

`ifdef BER_LOADER_RUN_TIMER_EN
   // RUN-length countdown.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tmr <= '0;
      else     tmr <= tmr_nxt;
   end
`endif

endmodule
